// File: rtl/alu_pkg.sv
// Shared types and sizing for the ALU issue/writeback slice.
package alu_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned NREGS  = 8;
    localparam int unsigned REG_AW = $clog2(NREGS);

    typedef enum logic [3:0] {
        OP_ADD    = 4'h0,
        OP_SUB    = 4'h1,
        OP_MUL    = 4'h2,
        OP_AND    = 4'h3,
        OP_OR     = 4'h4,
        OP_XOR    = 4'h5,
        OP_NOT    = 4'h6,
        OP_SHL    = 4'h7,
        OP_SHR    = 4'h8,
        OP_ROR2   = 4'h9,
        OP_ROR3   = 4'hA,
        OP_ROL2   = 4'hB,
        OP_ROL3   = 4'hC,
        OP_RSVD_D = 4'hD,
        OP_RSVD_E = 4'hE,
        OP_RSVD_F = 4'hF
    } alu_op_e;

    // Validity and destination of an instruction occupying a pipeline slot.
    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
    } issue_tag_t;

endpackage

// File: rtl/alu_regfile.sv
// Register file: r0 hardwired to zero, two async operand reads, one debug
// read, one synchronous write port, async active-low clear.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int unsigned DW    = alu_pkg::XLEN,
    parameter int unsigned DEPTH = alu_pkg::NREGS,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr1,
    output logic [DW-1:0] rdata1,
    input  logic [AW-1:0] raddr2,
    output logic [DW-1:0] rdata2,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);

    logic [DW-1:0] mem [DEPTH];

    // Storage update; writes to r0 are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    // Read ports; r0 forced to zero.
    always_comb begin
        rdata1   = (raddr1   == '0) ? '0 : mem[raddr1];
        rdata2   = (raddr2   == '0) ? '0 : mem[raddr2];
        dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue and writeback stage in front of the registered 64-bit ALU.
// Tracks two in-flight slots (s1: issued, s2: result on alu_result);
// s1 hazards stall one cycle, s2 hazards forward from alu_result.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned XLEN        = alu_pkg::XLEN,
    parameter int unsigned NREGS       = alu_pkg::NREGS,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_op,
    input  logic [2:0]             in_rd,
    input  logic [2:0]             in_rs1,
    input  logic [2:0]             in_rs2,
    input  logic                   in_use_imm,
    input  logic [XLEN-1:0]        in_imm,
    output logic [XLEN-1:0]        alu_a,
    output logic [XLEN-1:0]        alu_b,
    output logic [3:0]             alu_op,
    input  logic [XLEN-1:0]        alu_result,
    output logic                   wb_valid,
    output logic [2:0]             wb_rd,
    output logic [XLEN-1:0]        wb_data,
    input  logic [2:0]             dbg_addr,
    output logic [XLEN-1:0]        dbg_data,
    output logic [31:0]            retire_cnt,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    issue_tag_t     s1;
    issue_tag_t     s2;
    alu_op_e        op_q;
    logic [XLEN-1:0] rf_rd1;
    logic [XLEN-1:0] rf_rd2;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            hazard;
    logic            accept;

    alu_regfile #(
        .DW    (XLEN),
        .DEPTH (NREGS)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (s2.v),
        .waddr    (s2.rd),
        .wdata    (alu_result),
        .raddr1   (in_rs1),
        .rdata1   (rf_rd1),
        .raddr2   (in_rs2),
        .rdata2   (rf_rd2),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // Hazard against the slot whose result is not yet on alu_result.
    always_comb begin
        hazard = 1'b0;
        if (in_valid && s1.v) begin
            if ((in_rs1 != '0) && (s1.rd == in_rs1)) begin
                hazard = 1'b1;
            end
            if (!in_use_imm && (in_rs2 != '0) && (s1.rd == in_rs2)) begin
                hazard = 1'b1;
            end
        end
        in_ready = rst_n && !hazard;
        accept   = in_valid && in_ready;
    end

    // Operand selection: r0, then s2 forward, then register file.
    always_comb begin
        if (in_rs1 == '0) begin
            op_a = '0;
        end else if (s2.v && (s2.rd == in_rs1)) begin
            op_a = alu_result;
        end else begin
            op_a = rf_rd1;
        end

        if (in_use_imm) begin
            op_b = in_imm;
        end else if (in_rs2 == '0) begin
            op_b = '0;
        end else if (s2.v && (s2.rd == in_rs2)) begin
            op_b = alu_result;
        end else begin
            op_b = rf_rd2;
        end
    end

    // Issue registers: operands/opcode hold when idle, s1 tracks validity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a <= '0;
            alu_b <= '0;
            op_q  <= OP_ADD;
            s1    <= '0;
        end else if (accept) begin
            alu_a <= op_a;
            alu_b <= op_b;
            op_q  <= alu_op_e'(in_op);
            s1    <= '{v: 1'b1, rd: in_rd};
        end else begin
            s1.v  <= 1'b0;
        end
    end

    assign alu_op = op_q;

    // Result slot and writeback strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2       <= '0;
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
        end else begin
            s2       <= s1;
            wb_valid <= s2.v;
            if (s2.v) begin
                wb_rd   <= s2.rd;
                wb_data <= alu_result;
            end
        end
    end

    // Retire counter wraps; stall counter saturates at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (s2.v) begin
                retire_cnt <= retire_cnt + 32'd1;
            end
            if (in_valid && !in_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + STALL_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: behavioural ALU plus a program-order reference
// model (architectural values at issue, committed values at writeback).
module tb_alu_issue_stage;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [2:0]  in_rd, in_rs1, in_rs2;
    logic        in_use_imm;
    logic [63:0] in_imm;
    logic [63:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_op;
    logic        wb_valid;
    logic [2:0]  wb_rd;
    logic [63:0] wb_data;
    logic [2:0]  dbg_addr;
    logic [63:0] dbg_data;
    logic [31:0] retire_cnt;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    alu_issue_stage #(
        .XLEN        (64),
        .NREGS       (8),
        .STALL_CNT_W (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_use_imm (in_use_imm),
        .in_imm     (in_imm),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data),
        .retire_cnt (retire_cnt),
        .stall_cnt  (stall_cnt)
    );

    function automatic logic [63:0] alu_fn(input logic [63:0] a, input logic [63:0] b,
                                           input logic [3:0] op);
        case (op)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a * b;
            4'h3: return a & b;
            4'h4: return a | b;
            4'h5: return a ^ b;
            4'h6: return ~a;
            4'h7: return a << b[5:0];
            4'h8: return a >> b[5:0];
            4'h9: return {a[1:0], a[63:2]};
            4'hA: return {a[2:0], a[63:3]};
            4'hB: return {a[61:0], a[63:62]};
            4'hC: return {a[60:0], a[63:61]};
            default: return 64'd0;
        endcase
    endfunction

    // Behavioural clocked ALU driven by the stage under test.
    always_ff @(posedge clk) alu_result <= alu_fn(alu_a, alu_b, alu_op);

    typedef struct {
        int unsigned due;
        logic [2:0]  rd;
        logic [63:0] val;
    } pend_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] arch [8];
    logic [63:0] comm [8];
    pend_t       pq [$];
    int unsigned edge_n;
    logic        last_v;
    logic [2:0]  last_rd;
    logic [63:0] exp_a, exp_b, exp_wbd;
    logic [3:0]  exp_op;
    logic        exp_wbv;
    logic [2:0]  exp_wbrd;
    logic [31:0] exp_ret;
    logic [15:0] exp_stall;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            arch[i] = '0;
            comm[i] = '0;
        end
        pq.delete();
        last_v    = 1'b0;
        last_rd   = '0;
        exp_a     = '0;
        exp_b     = '0;
        exp_op    = '0;
        exp_wbv   = 1'b0;
        exp_wbrd  = '0;
        exp_wbd   = '0;
        exp_ret   = '0;
        exp_stall = '0;
    endtask

    // One clock: drive at negedge, advance model at posedge, check at next negedge.
    task automatic cycle(input logic v, input logic [3:0] op, input logic [2:0] rd,
                         input logic [2:0] rs1, input logic [2:0] rs2, input logic ui,
                         input logic [63:0] imm, input logic [2:0] da, output logic acc);
        logic        haz;
        logic [63:0] opa, opb;
        pend_t       p;
        in_valid   = v;
        in_op      = op;
        in_rd      = rd;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_use_imm = ui;
        in_imm     = imm;
        dbg_addr   = da;
        #1;
        haz = v && last_v && (last_rd != 0) &&
              ((rs1 == last_rd) || (!ui && (rs2 == last_rd)));
        check("in_ready", {63'd0, in_ready}, {63'd0, !haz});
        check("dbg_data", dbg_data, comm[da]);
        @(posedge clk);
        edge_n++;
        exp_wbv = 1'b0;
        if (pq.size() > 0 && pq[0].due == edge_n) begin
            p        = pq.pop_front();
            exp_wbv  = 1'b1;
            exp_wbrd = p.rd;
            exp_wbd  = p.val;
            exp_ret++;
            if (p.rd != 0) comm[p.rd] = p.val;
        end
        if (haz && exp_stall != 16'hFFFF) exp_stall++;
        acc = v && !haz;
        if (acc) begin
            opa    = arch[rs1];
            opb    = ui ? imm : arch[rs2];
            exp_a  = opa;
            exp_b  = opb;
            exp_op = op;
            p.due  = edge_n + 2;
            p.rd   = rd;
            p.val  = alu_fn(opa, opb, op);
            pq.push_back(p);
            if (rd != 0) arch[rd] = p.val;
        end
        last_v  = acc;
        last_rd = rd;
        @(negedge clk);
        check("alu_a", alu_a, exp_a);
        check("alu_b", alu_b, exp_b);
        check("alu_op", {60'd0, alu_op}, {60'd0, exp_op});
        check("wb_valid", {63'd0, wb_valid}, {63'd0, exp_wbv});
        if (exp_wbv) begin
            check("wb_rd", {61'd0, wb_rd}, {61'd0, exp_wbrd});
            check("wb_data", wb_data, exp_wbd);
        end
        check("retire_cnt", {32'd0, retire_cnt}, {32'd0, exp_ret});
        check("stall_cnt", {48'd0, stall_cnt}, {48'd0, exp_stall});
    endtask

    task automatic idle(input int n, input logic [2:0] da);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 4'h0, 3'd0, 3'd0, 3'd0, 1'b0, 64'd0, da, acc);
    endtask

    // Keep offering until accepted; a stall longer than the bound is a failure.
    task automatic offer(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic ui, input logic [63:0] imm);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 4 && !acc; i++) cycle(1'b1, op, rd, rs1, rs2, ui, imm, rd, acc);
        if (!acc) check("offer_accept", 64'd0, 64'd1);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        model_reset();
        #1;
        check("ready_in_reset", {63'd0, in_ready}, 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic acc;
        edge_n     = 0;
        in_op      = '0;
        in_rd      = '0;
        in_rs1     = '0;
        in_rs2     = '0;
        in_use_imm = 1'b0;
        in_imm     = '0;
        dbg_addr   = '0;
        do_reset();
        for (int i = 0; i < 8; i++) idle(1, 3'(i));

        // r1 = r0 + 5, then observe writeback and debug read.
        offer(4'h0, 3'd1, 3'd0, 3'd0, 1'b1, 64'd5);
        idle(3, 3'd1);

        // Dependent back-to-back: r1 = 5 then r2 = r1 + r1 (one stall).
        do_reset();
        offer(4'h0, 3'd1, 3'd0, 3'd0, 1'b1, 64'd5);
        offer(4'h0, 3'd2, 3'd1, 3'd1, 1'b0, 64'd0);
        idle(3, 3'd2);
        check("stall_once", {48'd0, stall_cnt}, 64'd1);

        // Distance-2 forward: r1 = 5, r3 = 9, r4 = r1 - 2.
        offer(4'h0, 3'd1, 3'd0, 3'd0, 1'b1, 64'd5);
        offer(4'h0, 3'd3, 3'd0, 3'd0, 1'b1, 64'd9);
        offer(4'h1, 3'd4, 3'd1, 3'd0, 1'b1, 64'd2);
        idle(3, 3'd4);
        check("r4_value", dbg_data, 64'd3);

        // Writes to r0 are dropped and never create a hazard.
        do_reset();
        offer(4'h0, 3'd0, 3'd0, 3'd0, 1'b1, 64'd7);
        offer(4'h0, 3'd5, 3'd0, 3'd0, 1'b1, 64'd1);
        idle(3, 3'd5);
        check("r0_retire_cnt", {32'd0, retire_cnt}, 64'd2);

        // Reset mid-flight discards the in-flight instruction.
        do_reset();
        cycle(1'b1, 4'h0, 3'd6, 3'd0, 3'd0, 1'b1, 64'hAA, 3'd6, acc);
        #2;
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("wb_in_reset", {63'd0, wb_valid}, 64'd0);
        end
        rst_n = 1'b1;
        idle(3, 3'd6);

        // Randomized traffic, biased toward few registers to provoke hazards.
        for (int i = 0; i < 600; i++) begin
            logic [2:0] rs1, rs2, rd;
            rd  = 3'($urandom_range(0, 3));
            rs1 = 3'($urandom_range(0, 3));
            rs2 = 3'($urandom_range(0, 7));
            cycle(($urandom % 4) != 0, 4'($urandom), rd, rs1, rs2, 1'($urandom),
                  {$urandom, $urandom}, 3'($urandom), acc);
        end
        idle(3, 3'd0);
        for (int i = 0; i < 8; i++) idle(1, 3'(i));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Issue and writeback stage sitting directly upstream of the 64-bit clocked ALU (ports a, b, op, result, clk).
- Accepts instructions over a valid/ready handshake, reads an 8-entry x 64-bit register file, and drives the ALU's operand and opcode inputs from registers.
- Tracks in-flight results across the ALU's one-cycle registered latency, resolving hazards by forwarding or a one-cycle stall, then writes results back to the register file.

Parameters:
XLEN, 64, datapath width; must match the ALU.
NREGS, 8, register count; register address width is log2(NREGS) = 3.
STALL_CNT_W, 16, width of the saturating stall counter.

Ports:
clk  in  1  clock, rising-edge; shared with the ALU.
rst_n  in  1  reset, asynchronous assert, active-low.
in_valid  in  1  instruction offered.
in_ready  out  1  stage can accept; combinational.
in_op  in  4  ALU opcode, passed through unmodified.
in_rd  in  3  destination register.
in_rs1  in  3  source register for operand a.
in_rs2  in  3  source register for operand b.
in_use_imm  in  1  1: operand b = in_imm; in_rs2 ignored.
in_imm  in  XLEN  immediate.
alu_a  out  XLEN  to ALU a; registered.
alu_b  out  XLEN  to ALU b; registered.
alu_op  out  4  to ALU op; registered.
alu_result  in  XLEN  from ALU result.
wb_valid  out  1  writeback strobe; registered.
wb_rd  out  3  writeback register.
wb_data  out  XLEN  writeback data.
dbg_addr  in  3  debug read address.
dbg_data  out  XLEN  register file contents at dbg_addr; combinational, no forwarding.
retire_cnt  out  32  writebacks since reset; wraps.
stall_cnt  out  STALL_CNT_W  hazard stall cycles; saturates at all-ones.

Behaviour:
- Reset (rst_n low, async):
  - All registers, alu_a, alu_b, alu_op, wb_* and both counters go to 0.
  - Pipeline valids s1_v and s2_v clear.
  - in_ready = 0 while rst_n is low.
  - In-flight instructions are discarded with no writeback.
- Accept: a transfer happens at a rising edge when in_valid && in_ready.
- Pipeline timing, for an instruction accepted at edge T:
  - T: alu_a, alu_b, alu_op load; s1 = {v=1, rd}.
  - T+1: the ALU registers its result; s2 takes s1.
  - During cycle T+1..T+2: alu_result is valid for s2.
  - T+2: wb_valid = 1, wb_rd = s2.rd, wb_data = alu_result; the register file writes.
  - Net issue-to-writeback latency: 2 cycles.
- Idle: with no accept, alu_a, alu_b and alu_op hold their values and s1_v goes to 0. The ALU still computes each cycle, but its result is ignored because validity is tracked only in s1/s2.
- Register 0:
  - Always reads as 0; writes to it are dropped.
  - wb_valid still pulses and retire_cnt still increments.
  - r0 never creates a hazard.
- Operand selection, per source rs (rs1 always; rs2 only when !in_use_imm):
  - rs == 0: value 0.
  - Else if s1_v && s1.rd == rs: hazard, stall.
  - Else if s2_v && s2.rd == rs: forward alu_result.
  - Else: register file read.
  - Priority is s1 > s2 > register file.
- Stall:
  - in_ready = rst_n && !hazard. The hazard term is evaluated from the offered in_rs1/in_rs2 whenever in_valid = 1.
  - A stall lasts exactly 1 cycle, because s1 moves to s2 at the next edge.
  - stall_cnt increments on each edge where in_valid && !in_ready && rst_n.
- Same-edge write/read: a register written at edge E and read for an accept at E is covered by the s2 forward; the register file needs no write-through.
- Back-to-back writes to the same rd: the younger (s1) stalls dependents; the older retires normally.
- Opcodes 0xD-0xF: issued and written back like any other; the ALU defines the result.
- Throughput: 1 instruction per cycle absent hazards.

Decomposition:
- Shared package alu_pkg:
  - XLEN, NREGS, REG_AW.
  - Opcode enum alu_op_e covering 0x0-0xF (ADD, SUB, MUL, AND, OR, XOR, NOT, SHL, SHR, ROR2, ROR3, ROL2, ROL3, RSVD_D/E/F).
  - Struct issue_tag_t {v, rd}.
- Sub-module alu_regfile:
  - NREGS x XLEN storage with r0 hardwired to 0.
  - 2 async read ports plus the dbg read port.
  - 1 sync write port; async active-low clear.

Test Plan:
- Reset: hold rst_n low 3 cycles then release -> in_ready=1, dbg_data=0 for all addresses, retire_cnt=0, stall_cnt=0, wb_valid=0.
- Load r1 with ADD, rs1=0, use_imm, imm=5, accepted at T:
  - After T: alu_a=0, alu_b=5, alu_op=0.
  - At T+2: wb_valid=1, wb_rd=1, wb_data=5.
  - dbg_addr=1 -> dbg_data=5.
- Dependent back-to-back: r1=5, then immediately offer ADD r2=r1+r1:
  - in_ready=0 for exactly 1 cycle, stall_cnt=1.
  - Issue proceeds with alu_a=alu_b=5 via s2 forward; r2=10.
- Distance-2 forward: r1=5, independent ADD r3=r0+imm 9, then SUB r4=r1-imm 2 -> no stall, alu_a=5 forwarded from alu_result, r4=3.
- r0 write: ADD rd=0, imm=7, then ADD r5=r0+imm 1 next cycle -> no stall, r0 stays 0, r5=1, retire_cnt=2.
- Reset mid-flight: accept r6=r0+imm 0xAA at T, drive rst_n low between T and T+1, release after 2 cycles -> no wb_valid, r6=0, retire_cnt=0.
